hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Central sequencing controller for the 5-stage pipeline. It issues per-stage stall, flush and bubble controls to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and selects EX operand forwarding. It also runs the data-memory request/ready handshake with a wait-state FSM and timeout. It sits beside the pipeline registers and has no datapath of its own.

## Interface
- MEM_TIMEOUT, 15, maximum dmem wait cycles before forced release (≥1)
- CNT_W, 16, width of the stall performance counter
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- id_ex_rs1, id_ex_rs2  in  5  source registers of the instruction in EX
- id_ex_rd  in  5  destination of the instruction in EX
- id_ex_memread  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- ex_mem_rd  in  5  destination in MEM
- ex_mem_regwrite  in  1  MEM instruction writes rd
- ex_mem_memread, ex_mem_memwrite  in  1  MEM instruction accesses dmem
- mem_wb_rd  in  5  destination in WB
- mem_wb_regwrite  in  1  WB instruction writes rd
- dmem_ready  in  1  data memory completes the current access this cycle
- dmem_req  out  1  data memory access request
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1  hold the register
- if_id_flush, id_ex_flush  out  1  load a NOP into the register
- mem_wb_bubble  out  1  load a NOP into MEM/WB
- fwd_a, fwd_b  out  2  EX operand source: 00 regfile, 01 WB result, 10 MEM result
- dmem_timeout  out  1  sticky: a dmem access was force-released
- stall_cnt  out  CNT_W  count of cycles with pc_stall=1, saturating

## Operation
- FSM states: RUN, MEMWAIT.
- Define mem_op = ex_mem_memread | ex_mem_memwrite. dmem_req = mem_op in both states.
- RUN:
  - If mem_op & ~dmem_ready: go to MEMWAIT and set wait_cnt=0.
  - This cycle, assert the freeze set: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_bubble all =1. Flushes and load-use stall are suppressed.
- MEMWAIT:
  - Freeze set is asserted while ~dmem_ready and wait_cnt < MEM_TIMEOUT-1. wait_cnt increments each cycle.
  - dmem_ready=1: freeze deasserts that cycle, go to RUN.
  - Ready still 0 when wait_cnt == MEM_TIMEOUT-1: freeze deasserts (forced release), dmem_timeout←1, go to RUN.
- Branch: ex_branch_taken & no freeze → if_id_flush=1 and id_ex_flush=1.
  - A branch arriving during a freeze stays held in EX. It flushes on the release cycle.
- Load-use:
  - Condition: no freeze, no taken branch, id_ex_memread, id_ex_rd≠0, and (id_uses_rs1 & id_rs1==id_ex_rd | id_uses_rs2 & id_rs2==id_ex_rd).
  - Response: pc_stall=1, if_id_stall=1, id_ex_flush=1.
- Priority: freeze > branch flush > load-use stall.
- Forwarding (combinational, always active):
  - fwd_a=10 if ex_mem_regwrite & ex_mem_rd≠0 & ex_mem_rd==id_ex_rs1.
  - Otherwise fwd_a=01 if mem_wb_regwrite & mem_wb_rd≠0 & mem_wb_rd==id_ex_rs1.
  - Otherwise fwd_a=00. fwd_b is the same using id_ex_rs2.
- stall_cnt increments on every cycle with pc_stall=1 and saturates at all-ones.
- dmem_timeout clears only on reset.

## Timing
- Reset (rst=0, asynchronous):
  - Registers: state=RUN, wait_cnt=0, dmem_timeout=0, stall_cnt=0.
  - All stall, flush, bubble and dmem_req outputs are forced to 0. fwd_a=fwd_b=00.
- Stall, flush, forwarding and dmem_req are combinational from inputs and registered state. There is zero-cycle latency; the pipeline registers act on the next clk edge.
- Single-cycle memory (dmem_ready=1 in the request cycle) causes no stall.
- Longest freeze is MEM_TIMEOUT cycles: one in RUN plus MEM_TIMEOUT-1 in MEMWAIT.
- Load-use costs exactly 1 stall cycle. The condition clears next cycle because the load has advanced.
- rst asserted mid-MEMWAIT abandons the access; dmem_req drops immediately.

## Structure
- Shared package hazard_pkg holds:
  - the state enum (RUN, MEMWAIT)
  - the fwd encodings FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
- Sub-module fwd_unit: purely combinational, instantiated once per operand (A and B).

## Test plan
- Forwarding:
  - ex_mem_rd=5 with regwrite, mem_wb_rd=5 with regwrite, id_ex_rs1=5 → fwd_a=10.
  - ex_mem_rd=0 with regwrite → fwd_a=00.
- Load-use: id_ex_memread=1, id_ex_rd=7, id_rs2=7, id_uses_rs2=1 → one cycle of pc_stall, if_id_stall and id_ex_flush; stall_cnt=1.
- Branch with load-use in the same cycle → if_id_flush=id_ex_flush=1, pc_stall=0.
- Memory wait: memread with dmem_ready low for 3 cycles → freeze set asserted for 3 cycles and deasserted on the ready cycle; dmem_timeout=0.
- Timeout: MEM_TIMEOUT=4, ready never asserted → freeze for 4 cycles, release on the 5th, dmem_timeout=1 sticky.
- Reset in MEMWAIT: rst=0 asynchronously → outputs 0 immediately; after release, state=RUN and stall_cnt=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// forwarding sub-units.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // x0 is hardwired to zero, so a write to it never produces a dependency.
    function automatic logic reg_hit(
        input logic             en,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs
    );
        return en && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EX source register; the younger MEM
// result takes precedence over the older WB result.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic             ex_mem_regwrite,
    input  logic [REG_W-1:0] mem_wb_rd,
    input  logic             mem_wb_regwrite,
    output logic [1:0]       sel
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        sel = FWD_REG;
        if (reg_hit(ex_mem_regwrite, ex_mem_rd, rs)) begin
            sel = FWD_MEM;
        end else if (reg_hit(mem_wb_regwrite, mem_wb_rd, rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/bubble generation, EX operand
// forwarding and the data-memory wait-state handshake with timeout.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,

    input  logic [REG_W-1:0] id_ex_rs1,
    input  logic [REG_W-1:0] id_ex_rs2,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             id_ex_memread,
    input  logic             ex_branch_taken,

    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic             ex_mem_regwrite,
    input  logic             ex_mem_memread,
    input  logic             ex_mem_memwrite,

    input  logic [REG_W-1:0] mem_wb_rd,
    input  logic             mem_wb_regwrite,

    input  logic             dmem_ready,
    output logic             dmem_req,

    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,

    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,

    output logic             dmem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              timeout_set;

    logic              mem_op;
    logic              freeze;
    logic              load_hit;
    logic              load_use;
    logic              branch_flush;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;

    assign mem_op = ex_mem_memread | ex_mem_memwrite;

    // ---------------------------------------------------------------
    // Memory wait-state FSM: next state and the freeze decision
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        freeze       = 1'b0;
        timeout_set  = 1'b0;
        case (state)
            RUN: begin
                if (mem_op && !dmem_ready) begin
                    freeze       = 1'b1;
                    state_nxt    = MEMWAIT;
                    wait_cnt_nxt = '0;
                end
            end
            MEMWAIT: begin
                if (dmem_ready) begin
                    state_nxt = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Forced release: the pipeline moves on without the data.
                    state_nxt   = RUN;
                    timeout_set = 1'b1;
                end else begin
                    freeze       = 1'b1;
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // ---------------------------------------------------------------
    // Branch flush and load-use detection, ordered below the freeze
    // ---------------------------------------------------------------
    assign load_hit = reg_hit(id_uses_rs1, id_ex_rd, id_rs1)
                    | reg_hit(id_uses_rs2, id_ex_rd, id_rs2);

    assign branch_flush = ex_branch_taken & ~freeze;
    assign load_use     = ~freeze & ~ex_branch_taken & id_ex_memread & load_hit;

    // All controls are held quiet while reset is asserted.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_bubble = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        dmem_req      = 1'b0;
        if (rst) begin
            pc_stall      = freeze | load_use;
            if_id_stall   = freeze | load_use;
            id_ex_stall   = freeze;
            ex_mem_stall  = freeze;
            mem_wb_bubble = freeze;
            if_id_flush   = branch_flush;
            id_ex_flush   = branch_flush | load_use;
            dmem_req      = mem_op;
        end
    end

    // ---------------------------------------------------------------
    // Forwarding
    // ---------------------------------------------------------------
    fwd_unit u_fwd_a (
        .rs              (id_ex_rs1),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .sel             (fwd_a_sel)
    );

    fwd_unit u_fwd_b (
        .rs              (id_ex_rs2),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .sel             (fwd_b_sel)
    );

    assign fwd_a = rst ? fwd_a_sel : FWD_REG;
    assign fwd_b = rst ? fwd_b_sel : FWD_REG;

    // ---------------------------------------------------------------
    // State, sticky timeout flag and saturating stall counter
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_timeout <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            if (timeout_set) begin
                dmem_timeout <= 1'b1;
            end
            if (pc_stall && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4 so
// the timeout and counter saturation are reachable in a few cycles).
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    // Control vector: {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    //                  mem_wb_bubble, if_id_flush, id_ex_flush, dmem_req}
    localparam logic [7:0] IDLE = 8'b0000_0000;
    localparam logic [7:0] REQ  = 8'b0000_0001;
    localparam logic [7:0] FRZ  = 8'b1111_1001;
    localparam logic [7:0] LU   = 8'b1100_0010;
    localparam logic [7:0] BR   = 8'b0000_0110;
    localparam logic [7:0] RELB = 8'b0000_0111;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic             id_uses_rs1, id_uses_rs2, id_ex_memread, ex_branch_taken;
    logic             ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, mem_wb_regwrite;
    logic             dmem_ready, dmem_req;
    logic             pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic             if_id_flush, id_ex_flush, mem_wb_bubble;
    logic [1:0]       fwd_a, fwd_b;
    logic             dmem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [7:0]       ctrl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ctrl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                   mem_wb_bubble, if_id_flush, id_ex_flush, dmem_req};

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_ex_rs1       (id_ex_rs1),
        .id_ex_rs2       (id_ex_rs2),
        .id_ex_rd        (id_ex_rd),
        .id_ex_memread   (id_ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .ex_mem_memread  (ex_mem_memread),
        .ex_mem_memwrite (ex_mem_memwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .dmem_ready      (dmem_ready),
        .dmem_req        (dmem_req),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .id_ex_stall     (id_ex_stall),
        .ex_mem_stall    (ex_mem_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_bubble   (mem_wb_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .dmem_timeout    (dmem_timeout),
        .stall_cnt       (stall_cnt)
    );

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0;
        id_ex_memread = 1'b0; ex_branch_taken = 1'b0;
        ex_mem_rd = '0; ex_mem_regwrite = 1'b0;
        ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0;
        mem_wb_rd = '0; mem_wb_regwrite = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic set_load_use();
        id_ex_memread = 1'b1; id_ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    endtask

    task automatic test_reset();
        ex_mem_memread = 1'b1; set_load_use();
        ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd5; id_ex_rs1 = 5'd5;
        #1;
        checks++;
        if (ctrl !== IDLE) begin errors++; $display("FAIL reset_ctrl got %b want %b", ctrl, IDLE); end
        checks++;
        if (fwd_a !== FWD_REG) begin errors++; $display("FAIL reset_fwd_a got %b want %b", fwd_a, FWD_REG); end
        checks++;
        if (dmem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", dmem_timeout); end
        @(negedge clk); #1;
        checks++;
        if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
        clear_inputs();
        rst = 1'b1;
    endtask

    task automatic test_forward();
        logic [1:0] ea, eb;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clear_inputs();
            ea = FWD_REG; eb = FWD_REG;
            case (i)
                0: begin ex_mem_rd = 5'd5;  ex_mem_regwrite = 1'b1; mem_wb_rd = 5'd5;  mem_wb_regwrite = 1'b1;
                         id_ex_rs1 = 5'd5;  id_ex_rs2 = 5'd3;  ea = FWD_MEM; eb = FWD_REG; end
                1: begin ex_mem_rd = 5'd0;  ex_mem_regwrite = 1'b1; mem_wb_rd = 5'd9;  mem_wb_regwrite = 1'b1;
                         id_ex_rs1 = 5'd0;  id_ex_rs2 = 5'd9;  ea = FWD_REG; eb = FWD_WB;  end
                2: begin ex_mem_rd = 5'd6;  ex_mem_regwrite = 1'b0; mem_wb_rd = 5'd6;  mem_wb_regwrite = 1'b1;
                         id_ex_rs1 = 5'd6;  id_ex_rs2 = 5'd6;  ea = FWD_WB;  eb = FWD_WB;  end
                3: begin ex_mem_rd = 5'd4;  ex_mem_regwrite = 1'b1; mem_wb_rd = 5'd8;  mem_wb_regwrite = 1'b1;
                         id_ex_rs1 = 5'd8;  id_ex_rs2 = 5'd4;  ea = FWD_WB;  eb = FWD_MEM; end
                4: begin ex_mem_rd = 5'd12; ex_mem_regwrite = 1'b1; mem_wb_rd = 5'd12; mem_wb_regwrite = 1'b0;
                         id_ex_rs1 = 5'd13; id_ex_rs2 = 5'd12; ea = FWD_REG; eb = FWD_MEM; end
                default: begin ex_mem_rd = 5'd3; ex_mem_regwrite = 1'b1; mem_wb_rd = 5'd0; mem_wb_regwrite = 1'b1;
                         id_ex_rs1 = 5'd0;  id_ex_rs2 = 5'd3;  ea = FWD_REG; eb = FWD_MEM; end
            endcase
            #1;
            checks++;
            if (fwd_a !== ea) begin errors++; $display("FAIL fwd_a_v%0d got %b want %b", i, fwd_a, ea); end
            checks++;
            if (fwd_b !== eb) begin errors++; $display("FAIL fwd_b_v%0d got %b want %b", i, fwd_b, eb); end
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        id_ex_memread = 1'b1; id_ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        #1;
        checks++;
        if (ctrl !== IDLE) begin errors++; $display("FAIL lu_rd0 got %b want %b", ctrl, IDLE); end
        @(negedge clk);
        id_ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
        #1;
        checks++;
        if (ctrl !== IDLE) begin errors++; $display("FAIL lu_unused got %b want %b", ctrl, IDLE); end
        @(negedge clk);
        id_uses_rs2 = 1'b1;
        #1;
        checks++;
        if (ctrl !== LU) begin errors++; $display("FAIL lu_rs2_hit got %b want %b", ctrl, LU); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (ctrl !== IDLE) begin errors++; $display("FAIL lu_clear got %b want %b", ctrl, IDLE); end
        checks++;
        if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt1 got %0d want 1", stall_cnt); end
        id_ex_memread = 1'b1; id_ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
        #1;
        checks++;
        if (ctrl !== LU) begin errors++; $display("FAIL lu_rs1_hit got %b want %b", ctrl, LU); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (stall_cnt !== 4'd2) begin errors++; $display("FAIL lu_cnt2 got %0d want 2", stall_cnt); end
    endtask

    task automatic test_branch();
        @(negedge clk);
        clear_inputs();
        set_load_use();
        ex_branch_taken = 1'b1;
        #1;
        checks++;
        if (ctrl !== BR) begin errors++; $display("FAIL br_over_lu got %b want %b", ctrl, BR); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (stall_cnt !== 4'd2) begin errors++; $display("FAIL br_cnt got %0d want 2", stall_cnt); end
    endtask

    task automatic test_mem_wait();
        @(negedge clk);
        clear_inputs();
        ex_mem_memwrite = 1'b1; dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctrl !== REQ) begin errors++; $display("FAIL mem_single got %b want %b", ctrl, REQ); end
        @(negedge clk);
        ex_mem_memwrite = 1'b0; ex_mem_memread = 1'b1; dmem_ready = 1'b0;
        ex_branch_taken = 1'b1; set_load_use();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (ctrl !== FRZ) begin errors++; $display("FAIL mem_wait_c%0d got %b want %b", c, ctrl, FRZ); end
            @(negedge clk);
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctrl !== RELB) begin errors++; $display("FAIL mem_ready_rel got %b want %b", ctrl, RELB); end
        checks++;
        if (dmem_timeout !== 1'b0) begin errors++; $display("FAIL mem_no_timeout got %b want 0", dmem_timeout); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (ctrl !== IDLE) begin errors++; $display("FAIL mem_after got %b want %b", ctrl, IDLE); end
        checks++;
        if (stall_cnt !== 4'd5) begin errors++; $display("FAIL mem_cnt got %0d want 5", stall_cnt); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        clear_inputs();
        ex_mem_memwrite = 1'b1;
        for (int c = 0; c < MEM_TIMEOUT; c++) begin
            #1;
            checks++;
            if (ctrl !== FRZ) begin errors++; $display("FAIL to_freeze_c%0d got %b want %b", c, ctrl, FRZ); end
            @(negedge clk);
        end
        #1;
        checks++;
        if (ctrl !== REQ) begin errors++; $display("FAIL to_release got %b want %b", ctrl, REQ); end
        checks++;
        if (dmem_timeout !== 1'b0) begin errors++; $display("FAIL to_flag_early got %b want 0", dmem_timeout); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (dmem_timeout !== 1'b1) begin errors++; $display("FAIL to_flag got %b want 1", dmem_timeout); end
        checks++;
        if (stall_cnt !== 4'd9) begin errors++; $display("FAIL to_cnt got %0d want 9", stall_cnt); end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (dmem_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", dmem_timeout); end
    endtask

    task automatic test_reset_memwait();
        @(negedge clk);
        clear_inputs();
        ex_mem_memread = 1'b1;
        ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd5; id_ex_rs1 = 5'd5;
        #1;
        checks++;
        if (ctrl !== FRZ) begin errors++; $display("FAIL rstw_run got %b want %b", ctrl, FRZ); end
        @(negedge clk);
        #1;
        checks++;
        if (ctrl !== FRZ) begin errors++; $display("FAIL rstw_wait got %b want %b", ctrl, FRZ); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ctrl !== IDLE) begin errors++; $display("FAIL rstw_ctrl got %b want %b", ctrl, IDLE); end
        checks++;
        if (fwd_a !== FWD_REG) begin errors++; $display("FAIL rstw_fwd got %b want %b", fwd_a, FWD_REG); end
        checks++;
        if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rstw_cnt got %0d want 0", stall_cnt); end
        checks++;
        if (dmem_timeout !== 1'b0) begin errors++; $display("FAIL rstw_flag got %b want 0", dmem_timeout); end
        @(negedge clk);
        rst = 1'b1;
        ex_mem_regwrite = 1'b0;
        // A fresh access from RUN must freeze for the full MEM_TIMEOUT cycles.
        for (int c = 0; c < MEM_TIMEOUT; c++) begin
            #1;
            checks++;
            if (ctrl !== FRZ) begin errors++; $display("FAIL rstw_post_c%0d got %b want %b", c, ctrl, FRZ); end
            @(negedge clk);
        end
        #1;
        checks++;
        if (ctrl !== REQ) begin errors++; $display("FAIL rstw_post_rel got %b want %b", ctrl, REQ); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (stall_cnt !== 4'd4) begin errors++; $display("FAIL rstw_post_cnt got %0d want 4", stall_cnt); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        clear_inputs();
        set_load_use();
        #1;
        checks++;
        if (ctrl !== LU) begin errors++; $display("FAIL sat_ctrl got %b want %b", ctrl, LU); end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_pre got %0d want 14", stall_cnt); end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", stall_cnt); end
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_memwait();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
